// File: rtl/cpu_cu_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
// Optional illegal-opcode trap is selected in the top by CPU_CU_ILLEGAL_TRAP_EN.
package cpu_cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_ALU,
        S_EXEC_LD,
        S_EXEC_ST,
        S_EXEC_JMP,
        S_EXEC_BR,
        S_HALT,
        S_ILLEGAL
    } state_e;

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_LD   = 3'b001;
    localparam logic [2:0] CLS_ST   = 3'b010;
    localparam logic [2:0] CLS_JMP  = 3'b011;
    localparam logic [2:0] CLS_BR   = 3'b100;
    localparam logic [2:0] CLS_ILL0 = 3'b101;
    localparam logic [2:0] CLS_ILL1 = 3'b110;
    localparam logic [2:0] CLS_HALT = 3'b111;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_Z      = 4'd1;
    localparam logic [3:0] COND_NZ     = 4'd2;
    localparam logic [3:0] COND_C      = 4'd3;
    localparam logic [3:0] COND_NC     = 4'd4;
    localparam logic [3:0] COND_N      = 4'd5;
    localparam logic [3:0] COND_NN     = 4'd6;

    localparam logic [3:0] ALU_PASS_R = 4'h0;
    localparam logic [3:0] ALU_PASS_S = 4'h1;

endpackage

// File: rtl/cu_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the latched
// C/N/Z flags to a take/not-take decision. Codes 7..15 never take.
module cu_cond_eval
    import cpu_cu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic       c_i,
    input  logic       n_i,
    input  logic       z_i,
    output logic       take_o
);

    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            COND_ALWAYS: take_o = 1'b1;
            COND_Z:      take_o = z_i;
            COND_NZ:     take_o = !z_i;
            COND_C:      take_o = c_i;
            COND_NC:     take_o = !c_i;
            COND_N:      take_o = n_i;
            COND_NN:     take_o = !n_i;
            default:     take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for the 16-bit RISC CPU (FETCH/DECODE/EXEC).
// Define CPU_CU_ILLEGAL_TRAP_EN to trap classes 101/110; otherwise they run as NOPs.
module cpu_control_unit
    import cpu_cu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        c_in,
    input  logic        n_in,
    input  logic        z_in,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        w_en,
    output logic [2:0]  w_adr,
    output logic [2:0]  r_adr,
    output logic [2:0]  s_adr,
    output logic [3:0]  alu_op,
    output logic        sel,
    output logic        adr_sel,
    output logic        ld_en,
    output logic        pc_inc,
    output logic        pc_sel,
    output logic        ir_en,
    output logic        halted,
    output logic        illegal
);

    state_e     state_q;
    logic       c_q, n_q, z_q;
    logic       take;
    logic [2:0] cls;

    assign cls = ir[15:13];

    cu_cond_eval u_cond (
        .cond_i (ir[11:8]),
        .c_i    (c_q),
        .n_i    (n_q),
        .z_i    (z_q),
        .take_o (take)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            // Flags only reflect the most recent ALU instruction.
            if (state_q == S_EXEC_ALU) begin
                c_q <= c_in;
                n_q <= n_in;
                z_q <= z_in;
            end
            case (state_q)
                S_FETCH: if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (cls)
                        CLS_ALU:  state_q <= S_EXEC_ALU;
                        CLS_LD:   state_q <= S_EXEC_LD;
                        CLS_ST:   state_q <= S_EXEC_ST;
                        CLS_JMP:  state_q <= S_EXEC_JMP;
                        CLS_BR:   state_q <= S_EXEC_BR;
                        CLS_HALT: state_q <= S_HALT;
`ifdef CPU_CU_ILLEGAL_TRAP_EN
                        CLS_ILL0, CLS_ILL1: state_q <= S_ILLEGAL;
`else
                        CLS_ILL0, CLS_ILL1: state_q <= S_FETCH;
`endif
                        default:  state_q <= S_FETCH;
                    endcase
                end
                S_EXEC_ALU, S_EXEC_JMP, S_EXEC_BR: state_q <= S_FETCH;
                S_EXEC_LD, S_EXEC_ST: if (mem_ready) state_q <= S_FETCH;
                S_HALT:    state_q <= S_HALT;
                S_ILLEGAL: state_q <= S_ILLEGAL;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    // Moore decode of state and ir; mem_ready only gates the completion strobes.
    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        w_en    = 1'b0;
        w_adr   = 3'd0;
        r_adr   = 3'd0;
        s_adr   = 3'd0;
        alu_op  = 4'd0;
        sel     = 1'b0;
        adr_sel = 1'b0;
        ld_en   = 1'b0;
        pc_inc  = 1'b0;
        pc_sel  = 1'b0;
        ir_en   = 1'b0;
        halted  = 1'b0;
        if (!reset) begin
            w_adr = ir[8:6];
            r_adr = ir[5:3];
            s_adr = ir[2:0];
            case (state_q)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    ir_en  = mem_ready;
                    pc_inc = mem_ready;
                end
                S_EXEC_ALU: begin
                    w_en   = 1'b1;
                    alu_op = ir[12:9];
                end
                S_EXEC_LD: begin
                    mem_rd  = 1'b1;
                    adr_sel = 1'b1;
                    sel     = 1'b1;
                    alu_op  = ALU_PASS_S;
                    w_en    = mem_ready;
                end
                S_EXEC_ST: begin
                    mem_wr  = 1'b1;
                    adr_sel = 1'b1;
                    alu_op  = ALU_PASS_S;
                end
                S_EXEC_JMP: begin
                    alu_op = ALU_PASS_R;
                    pc_sel = 1'b1;
                    ld_en  = 1'b1;
                end
                S_EXEC_BR: ld_en = take;
                S_HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CPU_CU_ILLEGAL_TRAP_EN
    assign illegal = !reset && (state_q == S_ILLEGAL);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: per-cycle expected output vectors
// are queued when stimulus is driven and compared when the outputs are sampled.
module tb_cpu_control_unit;

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic        c_in, n_in, z_in;
    logic        mem_ready;
    logic        mem_rd, mem_wr, w_en;
    logic [2:0]  w_adr, r_adr, s_adr;
    logic [3:0]  alu_op;
    logic        sel, adr_sel, ld_en, pc_inc, pc_sel, ir_en, halted, illegal;

    cpu_control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .c_in      (c_in),
        .n_in      (n_in),
        .z_in      (z_in),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .w_en      (w_en),
        .w_adr     (w_adr),
        .r_adr     (r_adr),
        .s_adr     (s_adr),
        .alu_op    (alu_op),
        .sel       (sel),
        .adr_sel   (adr_sel),
        .ld_en     (ld_en),
        .pc_inc    (pc_inc),
        .pc_sel    (pc_sel),
        .ir_en     (ir_en),
        .halted    (halted),
        .illegal   (illegal)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Vector layout: mem_rd mem_wr w_en w_adr r_adr s_adr alu_op sel adr_sel
    //                ld_en pc_inc pc_sel ir_en halted illegal
    logic [23:0] exp_q[$];
    logic [23:0] msk_q[$];
    int          tests_run = 0;
    int          failures  = 0;
    logic [15:0] cur_ir;

    localparam logic [23:0] M_ALL   = 24'hFFFFFF;
    localparam logic [23:0] M_NOALU = 24'hFFF07F;
    localparam logic [23:0] M_NOSEL = 24'hFFFF7F;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [15:0] ir;
        logic [2:0]  cnz;
        logic [23:0] exp;
        logic [23:0] mask;
    } row_t;

    function automatic row_t mk(input logic rst, input logic rdy, input logic [15:0] i,
                                 input logic [2:0] cnz, input logic [23:0] e, input logic [23:0] m);
        row_t r;
        r.rst = rst; r.rdy = rdy; r.ir = i; r.cnz = cnz; r.exp = e; r.mask = m;
        return r;
    endfunction

    function automatic logic [2:0] rf();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic rr();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [23:0] adr(input logic [15:0] i);
        return {3'b000, i[8:0], 12'h000};
    endfunction
    function automatic logic [23:0] ef(input logic [15:0] i, input logic rdy);
        return adr(i) | 24'h800000 | (rdy ? 24'h000014 : 24'h0);
    endfunction
    function automatic logic [23:0] ed(input logic [15:0] i);
        return adr(i);
    endfunction
    function automatic logic [23:0] ea(input logic [15:0] i);
        return adr(i) | 24'h200000 | {12'h000, i[12:9], 8'h00};
    endfunction
    function automatic logic [23:0] el(input logic [15:0] i, input logic rdy);
        return adr(i) | 24'h8001C0 | (rdy ? 24'h200000 : 24'h0);
    endfunction
    function automatic logic [23:0] es(input logic [15:0] i);
        return adr(i) | 24'h400140;
    endfunction
    function automatic logic [23:0] ej(input logic [15:0] i);
        return adr(i) | 24'h000028;
    endfunction
    function automatic logic [23:0] eb(input logic [15:0] i, input logic t);
        return adr(i) | (t ? 24'h000020 : 24'h0);
    endfunction
    function automatic logic [23:0] eh(input logic [15:0] i);
        return adr(i) | 24'h000002;
    endfunction
    function automatic logic [23:0] ei(input logic [15:0] i);
        return adr(i) | 24'h000001;
    endfunction

    function automatic logic [23:0] outs();
        return {mem_rd, mem_wr, w_en, w_adr, r_adr, s_adr, alu_op, sel, adr_sel,
                ld_en, pc_inc, pc_sel, ir_en, halted, illegal};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_row(input row_t r);
        reset     = r.rst;
        mem_ready = r.rdy;
        ir        = r.ir;
        {c_in, n_in, z_in} = r.cnz;
        exp_q.push_back(r.exp);
        msk_q.push_back(r.mask);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        row_t rows[$];
        logic [23:0] got, e, m;
        rows.push_back(mk(1'b1, 1'b1, 16'($urandom), rf(), 24'h0, M_ALL));
        rows.push_back(mk(1'b1, rr(), 16'hFFFF, rf(), 24'h0, M_ALL));
        rows.push_back(mk(1'b1, 1'b1, 16'hE000, rf(), 24'h0, M_ALL));
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL reset[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
        cur_ir = 16'h0000;
    endtask

    task automatic test_alu();
        row_t rows[$];
        logic [23:0] got, e, m;
        rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h0A53, rf(), ed(16'h0A53), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h0A53, 3'b000, ea(16'h0A53), M_ALL));
        rows.push_back(mk(1'b0, 1'b0, 16'h0A53, rf(), ef(16'h0A53, 1'b0), M_NOALU));
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL alu[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
        cur_ir = 16'h0A53;
    endtask

    task automatic test_load_wait();
        row_t rows[$];
        logic [23:0] got, e, m;
        rows.push_back(mk(1'b0, 1'b0, cur_ir, rf(), ef(cur_ir, 1'b0), M_NOALU));
        rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h2050, rf(), ed(16'h2050), M_NOALU));
        for (int i = 0; i < 3; i++)
            rows.push_back(mk(1'b0, 1'b0, 16'h2050, rf(), el(16'h2050, 1'b0), M_ALL));
        rows.push_back(mk(1'b0, 1'b1, 16'h2050, rf(), el(16'h2050, 1'b1), M_ALL));
        rows.push_back(mk(1'b0, 1'b0, 16'h2050, rf(), ef(16'h2050, 1'b0), M_NOALU));
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL load[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
        cur_ir = 16'h2050;
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [23:0] got, e, m;
        logic [2:0]  fl[8] = '{3'b001, 3'b000, 3'b100, 3'b100, 3'b010, 3'b010, 3'b000, 3'b111};
        logic [15:0] br[8] = '{16'h81FE, 16'h81FE, 16'h8305, 16'h8405, 16'h8510, 16'h8620, 16'h8000, 16'h8F00};
        logic        tk[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
            rows.push_back(mk(1'b0, rr(), 16'h0A53, rf(), ed(16'h0A53), M_NOALU));
            rows.push_back(mk(1'b0, rr(), 16'h0A53, {fl[i][2], fl[i][1], fl[i][0]}, ea(16'h0A53), M_ALL));
            rows.push_back(mk(1'b0, 1'b1, 16'h0A53, rf(), ef(16'h0A53, 1'b1), M_NOALU));
            rows.push_back(mk(1'b0, rr(), br[i], rf(), ed(br[i]), M_NOALU));
            rows.push_back(mk(1'b0, rr(), br[i], rf(), eb(br[i], tk[i]), M_NOALU));
            cur_ir = br[i];
        end
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL branch[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
    endtask

    task automatic test_jmp();
        row_t rows[$];
        logic [23:0] got, e, m;
        rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h6018, rf(), ed(16'h6018), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h6018, rf(), ej(16'h6018), M_NOSEL));
        rows.push_back(mk(1'b0, 1'b0, 16'h6018, rf(), ef(16'h6018, 1'b0), M_NOALU));
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL jmp[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
        cur_ir = 16'h6018;
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [23:0] got, e, m;
        rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h4013, rf(), ed(16'h4013), M_NOALU));
        rows.push_back(mk(1'b0, 1'b1, 16'h4013, rf(), es(16'h4013), M_NOSEL));
        rows.push_back(mk(1'b0, 1'b1, 16'h4013, rf(), ef(16'h4013, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h2050, rf(), ed(16'h2050), M_NOALU));
        rows.push_back(mk(1'b0, 1'b1, 16'h2050, rf(), el(16'h2050, 1'b1), M_ALL));
        rows.push_back(mk(1'b0, 1'b0, 16'h2050, rf(), ef(16'h2050, 1'b0), M_NOALU));
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
        cur_ir = 16'h2050;
    endtask

    task automatic test_reset_mid_store();
        row_t rows[$];
        logic [23:0] got, e, m;
        logic [15:0] br[4] = '{16'h81FE, 16'h8200, 16'h8300, 16'h8500};
        logic        tk[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h0A53, rf(), ed(16'h0A53), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h0A53, 3'b111, ea(16'h0A53), M_ALL));
        rows.push_back(mk(1'b0, 1'b1, 16'h0A53, rf(), ef(16'h0A53, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'h4013, rf(), ed(16'h4013), M_NOALU));
        rows.push_back(mk(1'b0, 1'b0, 16'h4013, rf(), es(16'h4013), M_NOSEL));
        rows.push_back(mk(1'b0, 1'b0, 16'h4013, rf(), es(16'h4013), M_NOSEL));
        rows.push_back(mk(1'b1, 1'b0, 16'h4013, rf(), 24'h0, M_ALL));
        rows.push_back(mk(1'b0, 1'b0, 16'h4013, rf(), ef(16'h4013, 1'b0), M_NOALU));
        cur_ir = 16'h4013;
        for (int i = 0; i < 4; i++) begin
            rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
            rows.push_back(mk(1'b0, rr(), br[i], rf(), ed(br[i]), M_NOALU));
            rows.push_back(mk(1'b0, rr(), br[i], rf(), eb(br[i], tk[i]), M_NOALU));
            cur_ir = br[i];
        end
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL rst_store[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        row_t rows[$];
        logic [23:0] got, e, m;
        rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
        rows.push_back(mk(1'b0, rr(), 16'hE000, rf(), ed(16'hE000), M_NOALU));
        for (int i = 0; i < 6; i++)
            rows.push_back(mk(1'b0, rr(), 16'hE000, rf(), eh(16'hE000), M_NOALU));
        rows.push_back(mk(1'b1, rr(), 16'hE000, rf(), 24'h0, M_ALL));
        rows.push_back(mk(1'b0, 1'b0, 16'hE000, rf(), ef(16'hE000, 1'b0), M_NOALU));
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL halt[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
        cur_ir = 16'hE000;
    endtask

    task automatic test_illegal();
        row_t rows[$];
        logic [23:0] got, e, m;
        logic [15:0] op[2] = '{16'hA000, 16'hC0D5};
        for (int i = 0; i < 2; i++) begin
            rows.push_back(mk(1'b0, 1'b1, cur_ir, rf(), ef(cur_ir, 1'b1), M_NOALU));
            rows.push_back(mk(1'b0, rr(), op[i], rf(), ed(op[i]), M_NOALU));
`ifdef CPU_CU_ILLEGAL_TRAP_EN
            for (int j = 0; j < 4; j++)
                rows.push_back(mk(1'b0, rr(), op[i], rf(), ei(op[i]), M_NOALU));
            rows.push_back(mk(1'b1, rr(), op[i], rf(), 24'h0, M_ALL));
            rows.push_back(mk(1'b0, 1'b0, op[i], rf(), ef(op[i], 1'b0), M_NOALU));
`else
            rows.push_back(mk(1'b0, 1'b0, op[i], rf(), ef(op[i], 1'b0), M_NOALU));
            rows.push_back(mk(1'b0, 1'b1, op[i], rf(), ef(op[i], 1'b1), M_NOALU));
            rows.push_back(mk(1'b0, rr(), 16'h0A53, rf(), ed(16'h0A53), M_NOALU));
            rows.push_back(mk(1'b0, rr(), 16'h0A53, rf(), ea(16'h0A53), M_ALL));
`endif
            cur_ir = op[i];
        end
        foreach (rows[k]) begin
            drive_row(rows[k]);
            got = outs(); e = exp_q.pop_front(); m = msk_q.pop_front();
            tests_run++;
            if ((got & m) !== (e & m)) begin
                failures++;
                $display("FAIL illegal[%0d] got=%h exp=%h mask=%h", k, got, e, m);
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; mem_ready = 1'b0; ir = 16'h0000;
        c_in = 1'b0; n_in = 1'b0; z_in = 1'b0;
        cur_ir = 16'h0000;
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_jmp();
        test_back_to_back();
        test_reset_mid_store();
        test_halt();
        test_illegal();
        tests_run++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
